// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and fetch stage for a 32-word instruction ROM,
//            with redirect, stall, ECALL/EBREAK halt, retire count and faults.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        resume,
  input  logic [31:0] instr_in,
  output logic [31:0] addr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] C_ROM_BYTES      = 32'(ROM_WORDS * 4);
  localparam logic [31:0] C_NOP            = 32'h0000_0013;
  localparam logic [31:0] C_ECALL          = 32'h0000_0073;
  localparam logic [31:0] C_EBREAK         = 32'h0010_0073;
  localparam logic [1:0]  C_CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  C_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  C_CAUSE_RANGE    = 2'b10;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [1:0]  r_cause, w_cause_nxt;
  logic [31:0] r_instret, w_instret_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_is_sys;
  logic        w_seq_oor;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_is_sys   = (instr_in == C_ECALL) || (instr_in == C_EBREAK);
  assign w_seq_oor  = (w_pc_plus4 >= C_ROM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_cause   <= C_CAUSE_NONE;
      r_instret <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_cause   <= w_cause_nxt;
      r_instret <= w_instret_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cause_nxt   = r_cause;
    w_instret_nxt = r_instret;
    case (r_state)
      ST_RUN: begin
        // A stalled instruction neither retires nor samples redirect/halt
        if (!stall) begin
          w_instret_nxt = r_instret + 32'd1;
          if (w_is_sys) begin
            w_state_nxt = ST_HALT;
          end else if (br_taken && (br_target[1:0] != 2'b00)) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = C_CAUSE_MISALIGN;
          end else if (br_taken && (br_target >= C_ROM_BYTES)) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = C_CAUSE_RANGE;
          end else if (br_taken) begin
            w_pc_nxt = br_target;
          end else if (w_seq_oor) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = C_CAUSE_RANGE;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          if (w_seq_oor) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = C_CAUSE_RANGE;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = w_pc_plus4;
          end
        end
      end
      default: begin
        // Only reset leaves the fault state
        w_state_nxt = ST_FAULT;
      end
    endcase
  end

  assign addr        = r_pc;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_out   = (r_state == ST_RUN) ? instr_in : C_NOP;
  assign valid       = (r_state == ST_RUN) && !stall;
  assign halted      = (r_state == ST_HALT);
  assign fault       = (r_state == ST_FAULT);
  assign fault_cause = r_cause;
  assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Self-checking bench for pc_fetch_unit against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] C_RESET_PC  = 32'h0;
  localparam int          C_WORDS     = 32;
  localparam logic [31:0] C_BYTES     = 32'd128;
  localparam logic [31:0] C_NOP       = 32'h0000_0013;
  localparam logic [31:0] C_ECALL     = 32'h0000_0073;
  localparam logic [31:0] C_EBREAK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        resume = 1'b0;
  logic [31:0] instr_in;
  logic [31:0] addr, pc_out, pc_plus4, instr_out, instret;
  logic        valid, halted, fault;
  logic [1:0]  fault_cause;

  logic [31:0] rom [C_WORDS];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_pc, m_cnt;
  logic        m_halt, m_fault;
  logic [1:0]  m_cause;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  always_comb instr_in = rom[addr[6:2]];

  pc_fetch_unit #(.RESET_PC(C_RESET_PC), .ROM_WORDS(C_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .resume(resume), .instr_in(instr_in),
    .addr(addr), .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_out(instr_out),
    .valid(valid), .halted(halted), .fault(fault), .fault_cause(fault_cause),
    .instret(instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = C_RESET_PC; m_cnt = 0; m_halt = 0; m_fault = 0; m_cause = 2'b00;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    return rom[pc / 4];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic [31:0] ins;
    if (m_fault) begin
    end else if (m_halt) begin
      if (resume) begin
        if (m_pc + 4 >= C_BYTES) begin m_halt = 0; m_fault = 1; m_cause = 2'b10; end
        else begin m_halt = 0; m_pc = m_pc + 4; end
      end
    end else if (!stall) begin
      m_cnt = m_cnt + 1;
      ins = model_word(m_pc);
      if (ins == C_ECALL || ins == C_EBREAK) m_halt = 1;
      else if (br_taken && (br_target % 4 != 0)) begin m_fault = 1; m_cause = 2'b01; end
      else if (br_taken && br_target >= C_BYTES)  begin m_fault = 1; m_cause = 2'b10; end
      else if (br_taken) m_pc = br_target;
      else if (m_pc + 4 >= C_BYTES) begin m_fault = 1; m_cause = 2'b10; end
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    logic run;
    run = !m_halt && !m_fault;
    check("addr", addr, m_pc);
    check("pc_out", pc_out, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr_out", instr_out, run ? model_word(m_pc) : C_NOP);
    check("valid", {31'd0, valid}, {31'd0, run && !stall});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("fault", {31'd0, fault}, {31'd0, m_fault});
    check("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
    check("instret", instret, m_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    stall = 0; br_taken = 0; br_target = 0; resume = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < C_WORDS; i++) rom[i] = C_NOP;
  endtask

  function automatic logic [31:0] enc_i(input int rd, input int rs1, input int imm);
    logic [31:0] w;
    w = 32'h13;
    w[11:7] = 5'(rd); w[19:15] = 5'(rs1); w[31:20] = 12'(imm);
    return w;
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = 32'h33;
    w[11:7] = 5'(rd); w[19:15] = 5'(rs1); w[24:20] = 5'(rs2);
    return w;
  endfunction

  function automatic logic [31:0] enc_blt(input int rs1, input int rs2, input int off);
    logic [12:0] imm;
    imm = 13'(off);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'b100, imm[4:1], imm[11], 7'h63};
  endfunction

  // Reference decoder: executes the instruction and drives the redirect inputs
  task automatic ref_exec();
    logic [31:0] ins, a, b, imm;
    ins = model_word(m_pc);
    br_taken = 0; br_target = 0;
    a = regs[ins[19:15]]; b = regs[ins[24:20]];
    case (ins[6:0])
      7'h13: if (ins[11:7] != 0) regs[ins[11:7]] = a + {{20{ins[31]}}, ins[31:20]};
      7'h33: if (ins[11:7] != 0) regs[ins[11:7]] = a + b;
      7'h63: begin
        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        br_target = m_pc + imm;
        br_taken = ($signed(a) < $signed(b));
      end
      default: ;
    endcase
  endtask

  initial begin
    bit done;
    fill_nop();
    model_reset();

    // Reset and sequential fetch
    apply_reset();
    repeat (3) tick();
    check("seq_addr", addr, 32'h0C);
    check("seq_instret", instret, 32'd3);
    check("seq_valid", {31'd0, valid}, 32'd1);
    check("seq_pc4", pc_plus4, 32'h10);

    // Loop program driven by the reference decoder
    fill_nop();
    rom[0] = enc_i(5, 0, 1);
    rom[1] = enc_i(6, 0, 0);
    rom[2] = enc_i(7, 0, 11);
    rom[3] = enc_blt(5, 7, 8);
    rom[4] = C_NOP;
    rom[5] = enc_add(6, 6, 5);
    rom[6] = enc_i(5, 5, 1);
    rom[7] = enc_blt(5, 7, -8);
    rom[8] = enc_i(10, 0, 10);
    rom[9] = C_ECALL;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    apply_reset();
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!m_halt) ref_exec();
      tick();
      if (m_halt) done = 1;
    end
    br_taken = 0;
    check("loop_done", {31'd0, done}, 32'd1);
    check("loop_halted", {31'd0, halted}, 32'd1);
    check("loop_pc", pc_out, 32'h24);
    check("loop_nop", instr_out, C_NOP);
    check("loop_instret", instret, 32'd36);
    check("loop_sum", regs[6], 32'd55);

    // Stall with a pending redirect
    fill_nop();
    apply_reset();
    repeat (2) tick();
    stall = 1; br_taken = 1; br_target = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_pc", addr, 32'h08);
      check("stall_valid", {31'd0, valid}, 32'd0);
      check("stall_instret", instret, 32'd2);
    end
    stall = 0;
    tick();
    check("stall_redirect", addr, 32'h40);
    br_taken = 0;

    // Misaligned redirect
    apply_reset();
    tick();
    br_taken = 1; br_target = 32'h06;
    tick();
    br_taken = 0; resume = 1;
    tick();
    resume = 0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_cause", {30'd0, fault_cause}, 32'd1);
    check("mis_pc", addr, 32'h04);

    // Out-of-range redirect
    apply_reset();
    br_taken = 1; br_target = 32'h80;
    tick();
    br_taken = 0; resume = 1;
    tick();
    resume = 0;
    check("oor_cause", {30'd0, fault_cause}, 32'd2);
    check("oor_pc", addr, 32'h00);

    // Sequential fall-off at the last ROM word
    apply_reset();
    br_taken = 1; br_target = 32'h7C;
    tick();
    br_taken = 0;
    tick();
    resume = 1;
    tick();
    resume = 0;
    check("fall_cause", {30'd0, fault_cause}, 32'd2);
    check("fall_pc", addr, 32'h7C);

    // Halt and resume
    rom[4] = C_ECALL;
    apply_reset();
    repeat (5) tick();
    check("halt_set", {31'd0, halted}, 32'd1);
    resume = 1;
    tick();
    resume = 0;
    check("resume_pc", addr, 32'h14);
    check("resume_instret", instret, 32'd5);
    check("resume_run", {31'd0, valid}, 32'd1);
    rom[4] = C_NOP;

    // Asynchronous reset between edges
    apply_reset();
    repeat (8) tick();
    check("pre_rst_pc", addr, 32'h20);
    check("pre_rst_cnt", instret, 32'd8);
    #2;
    rst_n = 0;
    #1;
    check("async_pc", addr, C_RESET_PC);
    check("async_cnt", instret, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Randomised traffic against the model
    for (int i = 0; i < C_WORDS; i++)
      rom[i] = ($urandom_range(0, 6) == 0) ? (($urandom_range(0, 1) == 1) ? C_ECALL : C_EBREAK)
                                           : $urandom;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      resume    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       br_target = 32'($urandom_range(32, 40)) * 4;
        1:       br_target = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        default: br_target = 32'($urandom_range(0, 31)) * 4;
      endcase
      tick();
      if (m_fault && $urandom_range(0, 4) == 0) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
